// File: rtl/puf_access_arbiter.sv
// Arbitrates two requesters onto the single PUF mapping core and sequences setup/trigger/done/release.
// Build option: define PUF_ARB_CAL_PRIORITY_EN for strict calibration priority instead of round-robin.
module puf_access_arbiter #(
    parameter int unsigned CHALLENGE_WIDTH = 32,
    parameter int unsigned RESPONSE_WIDTH  = 6,
    parameter int unsigned SETUP_CYCLES    = 2,
    parameter int unsigned REL_CYCLES      = 2,
    parameter int unsigned TIMEOUT         = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req,
    input  logic [CHALLENGE_WIDTH-1:0] challenge0,
    input  logic [CHALLENGE_WIDTH-1:0] challenge1,
    output logic [1:0]                 ack,
    output logic                       busy,
    output logic [CHALLENGE_WIDTH-1:0] puf_challenge,
    output logic                       puf_trigger,
    input  logic                       puf_done,
    input  logic [RESPONSE_WIDTH-1:0]  puf_raw,
    input  logic                       puf_xor,
    output logic                       rsp_valid,
    output logic                       rsp_id,
    output logic [RESPONSE_WIDTH-1:0]  rsp_raw,
    output logic                       rsp_xor,
    output logic                       rsp_timeout,
    output logic [7:0]                 timeout_count
);

    localparam logic [15:0] SETUP_LOAD = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] REL_LOAD   = 16'(REL_CYCLES - 1);
    localparam logic [7:0]  TO_LIMIT   = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ARMED,
        ST_RELEASE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_phase;
    logic [7:0]  r_to_cnt;
    logic        w_grant;
    logic        w_winner;
    logic        w_arm;
    logic        w_capture;
    logic        w_expire;
`ifndef PUF_ARB_CAL_PRIORITY_EN
    logic        r_last_grant;
`endif

    assign busy = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_arm       = 1'b0;
        w_capture   = 1'b0;
        w_expire    = 1'b0;
`ifdef PUF_ARB_CAL_PRIORITY_EN
        w_winner    = ~req[0];
`else
        w_winner    = (req == 2'b11) ? ~r_last_grant : req[1];
`endif
        case (r_state)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (r_phase == '0) begin
                    w_arm       = 1'b1;
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // Counter is compared before incrementing, so expiry lands TIMEOUT+1 cycles after trigger rise.
                if (puf_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RELEASE;
                end else if (r_to_cnt == TO_LIMIT) begin
                    w_expire    = 1'b1;
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if ((r_phase == '0) && !puf_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack           <= '0;
            puf_challenge <= '0;
            puf_trigger   <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_id        <= 1'b0;
            rsp_raw       <= '0;
            rsp_xor       <= 1'b0;
            rsp_timeout   <= 1'b0;
            timeout_count <= '0;
            r_phase       <= '0;
            r_to_cnt      <= '0;
`ifndef PUF_ARB_CAL_PRIORITY_EN
            r_last_grant  <= 1'b1;
`endif
        end else begin
            ack       <= '0;
            rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        ack           <= w_winner ? 2'b10 : 2'b01;
                        puf_challenge <= w_winner ? challenge1 : challenge0;
                        rsp_id        <= w_winner;
                        r_phase       <= SETUP_LOAD;
`ifndef PUF_ARB_CAL_PRIORITY_EN
                        r_last_grant  <= w_winner;
`endif
                    end
                end
                ST_SETUP: begin
                    if (w_arm) begin
                        puf_trigger <= 1'b1;
                        r_to_cnt    <= '0;
                    end else begin
                        r_phase <= r_phase - 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (w_capture) begin
                        rsp_valid   <= 1'b1;
                        rsp_raw     <= puf_raw;
                        rsp_xor     <= puf_xor;
                        rsp_timeout <= 1'b0;
                        puf_trigger <= 1'b0;
                        r_phase     <= REL_LOAD;
                    end else if (w_expire) begin
                        rsp_valid   <= 1'b1;
                        rsp_raw     <= '0;
                        rsp_xor     <= 1'b0;
                        rsp_timeout <= 1'b1;
                        puf_trigger <= 1'b0;
                        r_phase     <= REL_LOAD;
                        if (timeout_count != 8'hFF) begin
                            timeout_count <= timeout_count + 1'b1;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (r_phase != '0) begin
                        r_phase <= r_phase - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_access_arbiter.sv
// Directed self-checking bench for puf_access_arbiter (SETUP=2, REL=2, TIMEOUT=10).
module tb_puf_access_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [31:0] challenge0;
    logic [31:0] challenge1;
    logic [1:0]  ack;
    logic        busy;
    logic [31:0] puf_challenge;
    logic        puf_trigger;
    logic        puf_done;
    logic [5:0]  puf_raw;
    logic        puf_xor;
    logic        rsp_valid;
    logic        rsp_id;
    logic [5:0]  rsp_raw;
    logic        rsp_xor;
    logic        rsp_timeout;
    logic [7:0]  timeout_count;

    int n_checks = 0;
    int n_errors = 0;

    puf_access_arbiter #(
        .CHALLENGE_WIDTH(32),
        .RESPONSE_WIDTH (6),
        .SETUP_CYCLES   (2),
        .REL_CYCLES     (2),
        .TIMEOUT        (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .challenge0   (challenge0),
        .challenge1   (challenge1),
        .ack          (ack),
        .busy         (busy),
        .puf_challenge(puf_challenge),
        .puf_trigger  (puf_trigger),
        .puf_done     (puf_done),
        .puf_raw      (puf_raw),
        .puf_xor      (puf_xor),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_raw      (rsp_raw),
        .rsp_xor      (rsp_xor),
        .rsp_timeout  (rsp_timeout),
        .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input string tag, output logic [1:0] seen, output int n);
        n = 0;
        do begin tick(); n++; end while (ack == 2'b00 && n < 40);
        seen = ack;
        check(tag, 64'(ack != 2'b00), 64'd1);
    endtask

    task automatic wait_trig(input string tag, output int n);
        n = 0;
        do begin tick(); n++; end while (!puf_trigger && n < 40);
        check(tag, 64'(puf_trigger), 64'd1);
    endtask

    task automatic wait_rsp(input string tag, output int n);
        n = 0;
        do begin tick(); n++; end while (!rsp_valid && n < 60);
        check(tag, 64'(rsp_valid), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin tick(); n++; end while (busy && n < 60);
        check(tag, 64'(busy), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] a;
        int         n;
        int         cnt;
        logic       exp_id;

        req = 2'b00; challenge0 = '0; challenge1 = '0;
        puf_done = 1'b0; puf_raw = '0; puf_xor = 1'b0;
        do_reset();

        // Reset state
        check("rst_ack",   64'(ack), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_trig",  64'(puf_trigger), 64'd0);
        check("rst_chal",  64'(puf_challenge), 64'd0);
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_tocnt", 64'(timeout_count), 64'd0);

        // Single request, done 5 cycles after trigger, challenge changed after ack
        req = 2'b01; challenge0 = 32'hA5A5_0001;
        tick();
        check("s_ack", 64'(ack), 64'h1);
        check("s_chal", 64'(puf_challenge), 64'hA5A5_0001);
        check("s_busy", 64'(busy), 64'd1);
        req = 2'b00; challenge0 = 32'hDEAD_BEEF;
        tick();
        check("s_ack_pulse", 64'(ack), 64'h0);
        check("s_trig_setup", 64'(puf_trigger), 64'd0);
        tick();
        check("s_trig_rise", 64'(puf_trigger), 64'd1);
        cnt = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (puf_trigger && !rsp_valid) cnt++;
        end
        puf_done = 1'b1; puf_raw = 6'h2B; puf_xor = 1'b1;
        tick();
        check("s_trig_high_cycles", 64'(cnt), 64'd6);
        check("s_valid", 64'(rsp_valid), 64'd1);
        check("s_id", 64'(rsp_id), 64'd0);
        check("s_raw", 64'(rsp_raw), 64'h2B);
        check("s_xor", 64'(rsp_xor), 64'd1);
        check("s_timeout", 64'(rsp_timeout), 64'd0);
        check("s_trig_fall", 64'(puf_trigger), 64'd0);
        puf_done = 1'b0;
        tick();
        check("s_valid_pulse", 64'(rsp_valid), 64'd0);
        check("s_rel_busy", 64'(busy), 64'd1);
        check("s_chal_hold", 64'(puf_challenge), 64'hA5A5_0001);
        tick();
        check("s_idle", 64'(busy), 64'd0);

        // Simultaneous requests held for 4 transactions from fresh reset
        do_reset();
        challenge0 = 32'h0C0C_0000; challenge1 = 32'h0C1C_1111;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
`ifdef PUF_ARB_CAL_PRIORITY_EN
            exp_id = 1'b0;
`else
            exp_id = i[0];
`endif
            wait_ack("rr_ack_wait", a, n);
            check("rr_ack", 64'(a), exp_id ? 64'h2 : 64'h1);
            check("rr_chal", 64'(puf_challenge), exp_id ? 64'h0C1C_1111 : 64'h0C0C_0000);
            wait_trig("rr_trig_wait", n);
            check("rr_setup_len", 64'(n), 64'd2);
            puf_done = 1'b1; puf_raw = 6'(i + 1); puf_xor = i[0];
            wait_rsp("rr_rsp_wait", n);
            check("rr_dwell", 64'(n), 64'd1);
            check("rr_id", 64'(rsp_id), 64'(exp_id));
            check("rr_raw", 64'(rsp_raw), 64'(i + 1));
            puf_done = 1'b0;
        end
        req = 2'b10;
        wait_ack("rr_req1_wait", a, n);
        check("rr_req1_ack", 64'(a), 64'h2);
        req = 2'b00;
        wait_trig("rr_req1_trig", n);
        puf_done = 1'b1;
        wait_rsp("rr_req1_rsp", n);
        puf_done = 1'b0;
        wait_idle("rr_idle");

        // Done never asserts
        req = 2'b01;
        wait_ack("to_ack_wait", a, n);
        wait_trig("to_trig_wait", n);
        wait_rsp("to_rsp_wait", n);
        check("to_latency", 64'(n), 64'd11);
        check("to_flag", 64'(rsp_timeout), 64'd1);
        check("to_raw", 64'(rsp_raw), 64'd0);
        check("to_xor", 64'(rsp_xor), 64'd0);
        check("to_trig", 64'(puf_trigger), 64'd0);
        check("to_count1", 64'(timeout_count), 64'd1);
        for (int i = 1; i < 300; i++) begin
            wait_rsp("to_loop_wait", n);
            if (i == 254) check("to_count255", 64'(timeout_count), 64'd255);
        end
        check("to_count_sat", 64'(timeout_count), 64'd255);
        req = 2'b00;
        wait_idle("to_idle");

        // Done held high after capture with req[1] pending
        req = 2'b01; challenge0 = 32'h1111_2222;
        wait_ack("dh_ack_wait", a, n);
        req = 2'b10;
        wait_trig("dh_trig_wait", n);
        puf_done = 1'b1; puf_raw = 6'h07;
        wait_rsp("dh_rsp_wait", n);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy && ack == 2'b00) cnt++;
        end
        check("dh_stuck_busy", 64'(cnt), 64'd20);
        puf_done = 1'b0;
        tick();
        check("dh_idle", 64'(busy), 64'd0);
        check("dh_no_ack_yet", 64'(ack), 64'h0);
        tick();
        check("dh_ack1", 64'(ack), 64'h2);
        req = 2'b00;
        wait_trig("dh_trig2", n);
        puf_done = 1'b1;
        wait_rsp("dh_rsp2", n);
        check("dh_id", 64'(rsp_id), 64'd1);
        puf_done = 1'b0;
        wait_idle("dh_idle2");

        // Reset during ARMED, then a fresh req[1]
        req = 2'b01;
        wait_ack("ra_ack_wait", a, n);
        req = 2'b00;
        wait_trig("ra_trig_wait", n);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("ra_trig", 64'(puf_trigger), 64'd0);
        check("ra_busy", 64'(busy), 64'd0);
        check("ra_valid", 64'(rsp_valid), 64'd0);
        check("ra_chal", 64'(puf_challenge), 64'd0);
        check("ra_tocnt", 64'(timeout_count), 64'd0);
        check("ra_rsp", 64'({rsp_id, rsp_raw, rsp_xor, rsp_timeout, ack}), 64'd0);
        req = 2'b10; challenge1 = 32'h5555_AAAA;
        wait_ack("ra2_ack_wait", a, n);
        check("ra2_ack", 64'(a), 64'h2);
        check("ra2_chal", 64'(puf_challenge), 64'h5555_AAAA);
        req = 2'b00;
        wait_trig("ra2_trig", n);
        puf_done = 1'b1; puf_raw = 6'h15; puf_xor = 1'b0;
        wait_rsp("ra2_rsp", n);
        check("ra2_id", 64'(rsp_id), 64'd1);
        check("ra2_raw", 64'(rsp_raw), 64'h15);
        check("ra2_xor", 64'(rsp_xor), 64'd0);
        check("ra2_timeout", 64'(rsp_timeout), 64'd0);
        puf_done = 1'b0;
        wait_idle("ra2_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
